param_lfsr: RTL and testbench

//  Parametrised XNOR-feedback Fibonacci LFSR: the generalised successor to the fixed 64-bit test LFSR.

---
 rtl/param_lfsr_if.sv | 43 ++++
 rtl/param_lfsr.sv | 132 +++++++++++++
 tb/tb_param_lfsr.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/param_lfsr_if.sv
// rtl/param_lfsr_if.sv - control/status bundle for the parametrised LFSR
//
// Purpose : groups the LFSR control inputs and status outputs into one port.
// Modports: master drives seed/step/burst controls and observes status;
//           slave (the LFSR) receives controls and drives status.
// Signals : seed_load, seed, step_en, burst_start, burst_len   (master -> slave)
//           state, busy, done, lockup_seen                    (slave -> master)
//           data_in (master -> slave) only when LFSR_MISR_EN is defined
interface param_lfsr_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = 16
);
   logic             seed_load;
   logic [WIDTH-1:0] seed;
   logic             step_en;
   logic             burst_start;
   logic [CNT_W-1:0] burst_len;
   logic [WIDTH-1:0] state;
   logic             busy;
   logic             done;
   logic             lockup_seen;
`ifdef LFSR_MISR_EN
   logic [WIDTH-1:0] data_in;

   modport master (
      output seed_load, seed, step_en, burst_start, burst_len, data_in,
      input  state, busy, done, lockup_seen
   );
   modport slave (
      input  seed_load, seed, step_en, burst_start, burst_len, data_in,
      output state, busy, done, lockup_seen
   );
`else
   modport master (
      output seed_load, seed, step_en, burst_start, burst_len,
      input  state, busy, done, lockup_seen
   );
   modport slave (
      input  seed_load, seed, step_en, burst_start, burst_len,
      output state, busy, done, lockup_seen
   );
`endif
endinterface

// File: rtl/param_lfsr.sv
// rtl/param_lfsr.sv - parametrised XNOR Fibonacci LFSR with bursts and lock-up recovery
//
// Purpose : XNOR-feedback Fibonacci LFSR with seed load, free-run stepping,
//           counted bursts with a done pulse, and all-ones lock-up recovery.
// Ports   : clk_i       rising-edge clock
//           rst_ni      asynchronous active-low reset
//           bus         param_lfsr_if.slave (controls in, state/busy/done/lockup_seen out)
// Config  : LFSR_MISR_EN - when defined, bus.data_in is XORed into every step
//           (MISR compression), including the lock-up recovery value.
module param_lfsr #(
   parameter int unsigned      WIDTH     = 64,
   parameter logic [WIDTH-1:0] TAPS      = 64'h0000_0000_8000_2101,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      CNT_W     = 16
) (
   input logic         clk_i,
   input logic         rst_ni,
   param_lfsr_if.slave bus
);

   typedef enum logic {IDLE, BURST} fsm_e;

   fsm_e             fsm_q, fsm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] state_q, state_d;
   logic             done_q, done_d;
   logic             lockup_q, lockup_d;

   logic             fb;
   logic             all_ones;
   logic [WIDTH-1:0] step_val;
   logic             do_step;
   logic             burst_last;

   // Datapath: value the state takes if it steps this edge.
   always_comb begin
      fb       = ~^(state_q & TAPS);
      all_ones = &state_q;
      // All-ones is a fixed point under XNOR feedback; escape to RESET_VAL.
      if (all_ones) begin
         step_val = RESET_VAL;
      end else begin
         step_val = {fb, state_q[WIDTH-1:1]};
      end
`ifdef LFSR_MISR_EN
      step_val = step_val ^ bus.data_in;
`endif
   end

   assign burst_last = (cnt_q == CNT_W'(1));

   // A burst start consumes the edge, so free-run stepping only happens in
   // IDLE when neither seed load nor burst start is requested.
   assign do_step = !bus.seed_load &&
                    ((fsm_q == BURST) || (!bus.burst_start && bus.step_en));

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm_q    <= IDLE;
         cnt_q    <= '0;
         state_q  <= RESET_VAL;
         done_q   <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         done_q   <= done_d;
         lockup_q <= lockup_d;
      end
   end

   // Next-state logic: FSM and burst counter
   always_comb begin
      fsm_d = fsm_q;
      cnt_d = cnt_q;
      case (fsm_q)
         IDLE: begin
            if (!bus.seed_load && bus.burst_start && (bus.burst_len != '0)) begin
               fsm_d = BURST;
               cnt_d = bus.burst_len;
            end
         end
         BURST: begin
            if (bus.seed_load) begin
               fsm_d = IDLE;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (burst_last) begin
                  fsm_d = IDLE;
               end
            end
         end
         default: begin
            fsm_d = IDLE;
            cnt_d = '0;
         end
      endcase
   end

   // Output logic: LFSR state, done pulse, sticky lock-up flag
   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      lockup_d = lockup_q;
      if (bus.seed_load) begin
         // Seed is taken verbatim; an all-ones seed is caught on its next step.
         state_d  = bus.seed;
         lockup_d = 1'b0;
      end else begin
         if (do_step) begin
            state_d = step_val;
            if (all_ones) begin
               lockup_d = 1'b1;
            end
         end
         if (fsm_q == BURST) begin
            done_d = burst_last;
         end else if (bus.burst_start && (bus.burst_len == '0)) begin
            done_d = 1'b1;
         end
      end
   end

   assign bus.state       = state_q;
   assign bus.busy        = (fsm_q == BURST);
   assign bus.done        = done_q;
   assign bus.lockup_seen = lockup_q;

endmodule

// File: tb/tb_param_lfsr.sv
// tb/tb_param_lfsr.sv - self-checking bench for param_lfsr
module tb_param_lfsr;
   localparam int unsigned WIDTH = 64;
   localparam int unsigned CNT_W = 16;
   localparam logic [63:0] TAPS  = 64'h0000_0000_8000_2101;
   localparam logic [63:0] RVAL  = 64'h0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   param_lfsr_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   param_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS), .RESET_VAL(RVAL), .CNT_W(CNT_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   logic [63:0] din;
`ifdef LFSR_MISR_EN
   assign din = bus.data_in;
`else
   assign din = 64'h0;
`endif

   // Reference model: state as a number, burst as "steps remaining".
   logic [63:0] m_state;
   int          m_left;
   logic        m_done;
   logic        m_lock;

   function automatic logic [63:0] adv(input logic [63:0] s, input logic [63:0] d);
      logic fb;
      if (s == 64'hFFFF_FFFF_FFFF_FFFF) return RVAL ^ d;
      fb = (($countones(s & TAPS) % 2) == 0);
      return {fb, s[63:1]} ^ d;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= RVAL;
         m_left  <= 0;
         m_done  <= 1'b0;
         m_lock  <= 1'b0;
      end else if (bus.seed_load) begin
         m_state <= bus.seed;
         m_left  <= 0;
         m_done  <= 1'b0;
         m_lock  <= 1'b0;
      end else if (m_left > 0) begin
         m_state <= adv(m_state, din);
         if (m_state == 64'hFFFF_FFFF_FFFF_FFFF) m_lock <= 1'b1;
         m_left  <= m_left - 1;
         m_done  <= (m_left == 1);
      end else if (bus.burst_start) begin
         m_left  <= int'(bus.burst_len);
         m_done  <= (bus.burst_len == 0);
      end else begin
         m_done  <= 1'b0;
         if (bus.step_en) begin
            m_state <= adv(m_state, din);
            if (m_state == 64'hFFFF_FFFF_FFFF_FFFF) m_lock <= 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, DUT vs model.
   always @(negedge clk) begin
      check("state", bus.state, m_state);
      check("busy", {63'b0, bus.busy}, {63'b0, (m_left > 0)});
      check("done", {63'b0, bus.done}, {63'b0, m_done});
      check("lockup", {63'b0, bus.lockup_seen}, {63'b0, m_lock});
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.seed_load   = 1'b0;
      bus.seed        = 64'h0;
      bus.step_en     = 1'b0;
      bus.burst_start = 1'b0;
      bus.burst_len   = '0;
`ifdef LFSR_MISR_EN
      bus.data_in     = 64'h0;
`endif
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check("rst_state", bus.state, 64'h0);
      check("rst_busy", {63'b0, bus.busy}, 64'h0);
      check("rst_done", {63'b0, bus.done}, 64'h0);
      check("rst_lock", {63'b0, bus.lockup_seen}, 64'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      clear_inputs();
      edge1();
      edge1();
      check("reset_state", bus.state, 64'h0);
      check("reset_busy", {63'b0, bus.busy}, 64'h0);
      rst_n = 1'b1;

      // 1. free-run two steps
      bus.step_en = 1'b1;
      edge1(); check("t1_step1", bus.state, 64'h8000_0000_0000_0000);
      edge1(); check("t1_step2", bus.state, 64'hC000_0000_0000_0000);
      bus.step_en = 1'b0;
      pulse_reset();

      // 2. burst of 3
      bus.burst_start = 1'b1; bus.burst_len = 16'd3;
      edge1(); bus.burst_start = 1'b0;
      check("t2_busy0", {63'b0, bus.busy}, 64'h1);
      check("t2_nostep", bus.state, 64'h0);
      edge1(); check("t2_busy1", {63'b0, bus.busy}, 64'h1);
      edge1(); check("t2_busy2", {63'b0, bus.busy}, 64'h1);
      edge1();
      check("t2_final", bus.state, 64'hE000_0000_0000_0000);
      check("t2_done", {63'b0, bus.done}, 64'h1);
      check("t2_idle", {63'b0, bus.busy}, 64'h0);
      edge1(); check("t2_done_drop", {63'b0, bus.done}, 64'h0);

      // 3. zero-length burst
      bus.burst_start = 1'b1; bus.burst_len = 16'd0;
      edge1(); bus.burst_start = 1'b0;
      check("t3_done", {63'b0, bus.done}, 64'h1);
      check("t3_busy", {63'b0, bus.busy}, 64'h0);
      check("t3_state", bus.state, 64'hE000_0000_0000_0000);
      edge1(); check("t3_done_drop", {63'b0, bus.done}, 64'h0);

      // 4. lock-up recovery
      bus.seed_load = 1'b1; bus.seed = 64'hFFFF_FFFF_FFFF_FFFF;
      edge1(); bus.seed_load = 1'b0;
      check("t4_seed", bus.state, 64'hFFFF_FFFF_FFFF_FFFF);
      bus.step_en = 1'b1;
      edge1(); bus.step_en = 1'b0;
      check("t4_recover", bus.state, 64'h0);
      check("t4_lock", {63'b0, bus.lockup_seen}, 64'h1);
      bus.seed_load = 1'b1; bus.seed = 64'h5;
      edge1(); bus.seed_load = 1'b0;
      check("t4_lock_clr", {63'b0, bus.lockup_seen}, 64'h0);

      // 5. seed load aborts burst; reset mid-burst
      bus.burst_start = 1'b1; bus.burst_len = 16'd10;
      edge1(); bus.burst_start = 1'b0;
      edge1(); edge1();
      bus.seed_load = 1'b1; bus.seed = 64'h1234_5678_9ABC_DEF0;
      edge1(); bus.seed_load = 1'b0;
      check("t5_abort_state", bus.state, 64'h1234_5678_9ABC_DEF0);
      check("t5_abort_busy", {63'b0, bus.busy}, 64'h0);
      check("t5_abort_done", {63'b0, bus.done}, 64'h0);
      edge1(); check("t5_no_done", {63'b0, bus.done}, 64'h0);
      bus.burst_start = 1'b1; bus.burst_len = 16'd10;
      edge1(); bus.burst_start = 1'b0;
      edge1(); check("t5_busy_pre", {63'b0, bus.busy}, 64'h1);
      pulse_reset();

`ifdef LFSR_MISR_EN
      // 6. MISR compression from reset
      bus.data_in = 64'h1; bus.step_en = 1'b1;
      edge1(); bus.step_en = 1'b0; bus.data_in = 64'h0;
      check("t6_misr", bus.state, 64'h8000_0000_0000_0001);
`endif

      // Randomized phase
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            edge1();
            rst_n = 1'b1;
         end
         bus.seed_load   = ($urandom_range(0, 9) == 0);
         bus.seed        = ($urandom_range(0, 2) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                       : {$urandom, $urandom};
         bus.burst_start = ($urandom_range(0, 6) == 0);
         bus.burst_len   = 16'($urandom_range(0, 12));
         bus.step_en     = $urandom_range(0, 1) == 1;
`ifdef LFSR_MISR_EN
         bus.data_in     = ($urandom_range(0, 1) == 0) ? 64'h0 : {$urandom, $urandom};
`endif
         edge1();
      end
      clear_inputs();
      edge1();
      edge1();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
